// File: rtl/stream_sel_pkg.sv
// stream_sel_pkg: shared definitions for the stream selector.
//   mode_e     : encoding of the 2-bit mode port (FIXED, ROUND_ROBIN, FREEZE, BLANK)
//   clog2_u    : ceiling log2 for elaboration-time sizing
//   ch_width   : channel index width, never less than one bit
package stream_sel_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_RR     = 2'd1,
    MODE_FREEZE = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  function automatic int unsigned clog2_u(input int unsigned n);
    int unsigned w;
    w = 0;
    if (n > 1) begin
      for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

  function automatic int unsigned ch_width(input int unsigned n);
    return (clog2_u(n) == 0) ? 1 : clog2_u(n);
  endfunction

endpackage

// File: rtl/stream_sel_sched_period_timer.sv
// period_timer: free-running hold-period counter.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   period   : hold period in clocks, 0 behaves as 1; sampled live
//   term     : high while the coming rising edge is a terminal edge
// The >= compare lets a period shrink below the current count end the
// period on the next edge instead of wrapping through the full range.
module period_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] eff_m1;

  always_comb begin
    eff_m1 = (period == '0) ? '0 : period - CNT_W'(1);
    term   = (cnt_q >= eff_m1);
    cnt_d  = term ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_sel_sched.sv
// stream_sel_sched: N-channel data-stream selector with programmable hold.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   mode       : 0 FIXED, 1 ROUND_ROBIN, 2 FREEZE, 3 BLANK
//   sel        : channel index for FIXED mode
//   period     : hold period in clocks (0 behaves as 1)
//   din        : flattened channels, channel k at [k*DATA_W +: DATA_W]
//   din_valid  : per-channel valid
//   d_out      : registered selected data
//   d_valid    : registered valid for d_out
//   cur_ch     : channel currently on d_out
//   tick       : one-cycle pulse in the cycle after each update edge
// Optional macro STREAM_SEL_SKIP_INVALID_EN: round-robin skips channels
// whose valid is low; with none valid, data and channel hold and d_valid
// drops.
module stream_sel_sched
  import stream_sel_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [CH_W-1:0]          sel,
  input  logic [CNT_W-1:0]         period,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        din_valid,
  output logic [DATA_W-1:0]        d_out,
  output logic                     d_valid,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     tick
);

  // Channels padded to a power of two so any CH_W-bit index stays in range.
  localparam int unsigned SLOTS = 2 ** CH_W;

  logic [SLOTS*DATA_W-1:0] din_pad;
  logic [SLOTS-1:0]        vld_pad;
  logic                    term;
  mode_e                   mode_s;

  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_valid_q, d_valid_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              tick_q, tick_d;

  assign din_pad = (SLOTS*DATA_W)'(din);
  assign vld_pad = SLOTS'(din_valid);
  assign mode_s  = mode_e'(mode);

  period_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .period(period),
    .term  (term)
  );

`ifdef STREAM_SEL_SKIP_INVALID_EN
  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic [CH_W-1:0] pick_nxt;

  // Cyclic search for the first valid channel starting at rr_ptr.
  always_comb begin
    int unsigned c;
    pick_found = 1'b0;
    pick_idx   = '0;
    c          = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = 32'(rr_ptr_q) + i;
      if (c >= NUM_CH) begin
        c = c - NUM_CH;
      end
      if (!pick_found && vld_pad[c[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = c[CH_W-1:0];
      end
    end
    pick_nxt = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_W'(1);
  end
`endif

  always_comb begin
    d_out_d   = d_out_q;
    d_valid_d = d_valid_q;
    cur_ch_d  = cur_ch_q;
    rr_ptr_d  = rr_ptr_q;
    tick_d    = term;
    if (term) begin
      case (mode_s)
        MODE_FIXED: begin
          if (32'(sel) < NUM_CH) begin
            d_out_d   = din_pad[sel*DATA_W +: DATA_W];
            d_valid_d = vld_pad[sel];
            cur_ch_d  = sel;
          end else begin
            d_out_d   = '0;
            d_valid_d = 1'b0;
          end
        end
        MODE_RR: begin
`ifdef STREAM_SEL_SKIP_INVALID_EN
          if (pick_found) begin
            d_out_d   = din_pad[pick_idx*DATA_W +: DATA_W];
            d_valid_d = 1'b1;
            cur_ch_d  = pick_idx;
            rr_ptr_d  = pick_nxt;
          end else begin
            d_valid_d = 1'b0;
          end
`else
          d_out_d   = din_pad[rr_ptr_q*DATA_W +: DATA_W];
          d_valid_d = vld_pad[rr_ptr_q];
          cur_ch_d  = rr_ptr_q;
          rr_ptr_d  = (rr_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_ptr_q + CH_W'(1);
`endif
        end
        MODE_FREEZE: begin
        end
        MODE_BLANK: begin
          d_out_d   = '0;
          d_valid_d = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      cur_ch_q  <= '0;
      rr_ptr_q  <= '0;
      tick_q    <= 1'b0;
    end else begin
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      cur_ch_q  <= cur_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      tick_q    <= tick_d;
    end
  end

  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign cur_ch  = cur_ch_q;
  assign tick    = tick_q;

endmodule

// File: doc/stream_sel_sched.md
Name: stream_sel_sched

Overview:
Parametrised N-channel data-stream selector with a programmable hold period. Every `period` clocks it latches one input channel onto a registered output.
- Channel choice: a fixed select, a round-robin scheduler, freeze or blank.
- Adds per-channel valid, a terminal-count tick and current-channel reporting.
- Sits between the data-source generators and downstream display/serial logic.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 8, width of each channel and of d_out
CNT_W, 8, width of the period counter and the period port
(derived constant CH_W = max(1, clog2(NUM_CH)))

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
mode  in  2  0=FIXED, 1=ROUND_ROBIN, 2=FREEZE, 3=BLANK
sel  in  CH_W  channel index used in FIXED mode
period  in  CNT_W  hold period in clocks; 0 is treated as 1
din  in  NUM_CH*DATA_W  flattened channels, channel k at bits [k*DATA_W +: DATA_W]
din_valid  in  NUM_CH  per-channel valid
d_out  out  DATA_W  registered selected data
d_valid  out  1  registered valid accompanying d_out
cur_ch  out  CH_W  channel currently on d_out
tick  out  1  one-cycle pulse, registered, asserted the cycle after each update edge

Behaviour:
- Reset (rst high at a rising edge) clears the following: cnt, d_out, d_valid, cur_ch, tick and the internal rr_ptr are all 0.
- Reset mid-count aborts the period. No update occurs on the reset edge.
- Effective period: eff = (period==0) ? 1 : period.
- Terminal edge: a rising edge where cnt >= eff-1.
  - On it: cnt <= 0, the update is performed and tick <= 1.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
  - The >= compare makes an on-the-fly period shrink terminate on the next edge rather than wrapping.
- The first terminal edge is the eff-th rising edge after rst deasserts.
- mode, sel and period are sampled live every cycle. A mode or sel change has effect only at the next terminal edge.
- Update actions per mode:
  - FIXED:
    - If sel < NUM_CH: d_out <= din[sel], d_valid <= din_valid[sel], cur_ch <= sel.
    - If sel >= NUM_CH: d_out <= 0, d_valid <= 0, cur_ch unchanged.
  - ROUND_ROBIN: d_out <= din[rr_ptr], d_valid <= din_valid[rr_ptr], cur_ch <= rr_ptr, rr_ptr <= (rr_ptr==NUM_CH-1) ? 0 : rr_ptr+1.
    - rr_ptr persists across mode changes and is cleared only by rst.
  - FREEZE: d_out, d_valid and cur_ch hold. tick still pulses.
  - BLANK: d_out <= 0, d_valid <= 0, cur_ch unchanged.
- Latency: din sampled at the terminal edge appears on d_out immediately after that edge. tick is high during the following cycle.
- Arithmetic: the counter is unsigned CNT_W. period = 2^CNT_W-1 is legal; the counter never overflows because it wraps at eff-1.

Optional Feature:
STREAM_SEL_SKIP_INVALID_EN
- With the macro: in ROUND_ROBIN, the update selects the first channel k at or after rr_ptr (searching cyclically) whose din_valid[k]=1, then sets rr_ptr <= k+1 (wrapping).
  - If no channel is valid: d_out and cur_ch hold, d_valid <= 0, rr_ptr unchanged.
- Without the macro: strict rotation. Invalid channels are output with d_valid=0.

Decomposition:
- Package stream_sel_pkg: mode encoding constants (MODE_FIXED, MODE_RR, MODE_FREEZE, MODE_BLANK) and a clog2 helper function.
- One sub-module, period_timer (clk, rst, period → terminal pulse). It owns cnt and the period==0 rule.
- The selection/scheduling logic stays in the top.

Test Plan:
1. NUM_CH=4, mode=FIXED, sel=1, period=3, din[1]=8'hA5, din_valid=4'b0010 → first update on the 3rd edge after reset (d_out=A5, d_valid=1, cur_ch=1), then tick every 3 cycles.
2. period=0, mode=FIXED, sel=2, din[2] incrementing each clock → d_out follows din[2] with 1-cycle latency and tick stays high continuously.
3. mode=ROUND_ROBIN, period=2, din[k]=k+8'h10 → d_out sequence 10,11,12,13,10 with cur_ch 0,1,2,3,0, each held 2 cycles.
4. period=10, change period to 2 when cnt=5 → terminal edge on the next clock, after which updates occur every 2 cycles. Assert rst for one edge mid-period → all outputs 0 and the count restarts.
5. sel=3 with NUM_CH=3 → d_out=0, d_valid=0 and cur_ch holds. FREEZE → d_out holds while tick keeps pulsing. BLANK → d_out=0.
6. With STREAM_SEL_SKIP_INVALID_EN, RR, din_valid=4'b1010 → cur_ch 1,3,1,3. Then din_valid=0 → d_valid=0 and d_out holds.
